// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add / restoring divide, XLEN+1 cycles start-to-done (1 for div-by-zero/overflow).
// Backpressure: stall holds the front of the pipe from the accepting cycle until done; flush aborts at any point.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        fn;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] acc;
  logic              neg_res;
  logic              neg_rem;
  logic              done_q;

  // Operand decode on the incoming instruction
  logic            is_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_val;

  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sa       = a_signed & op_a[XLEN-1];
    sb       = b_signed & op_b[XLEN-1];
    mag_a    = sa ? -op_a : op_a;
    mag_b    = sb ? -op_b : op_b;
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !funct3[0] && (op_a == MIN_VAL) && (op_b == '1);
    fast_val = '0;
    if (div_zero)
      fast_val = funct3[1] ? op_a : '1;
    else if (div_ovf)
      fast_val = funct3[1] ? '0 : MIN_VAL;
  end

  // One iteration of the datapath; acc holds {hi, lo} = {product hi, multiplier} or {remainder, quotient}
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] acc_nxt;

  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, mcand};
    if (fn[2]) begin
      if (!diff[XLEN])
        acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Sign fix-up and result select on the final iteration's output
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, final_val;

  always_comb begin
    prod = neg_res ? -acc_nxt : acc_nxt;
    quo  = neg_res ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem  = neg_rem ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    case (fn)
      3'b000:                 final_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_val = quo;
      default:                final_val = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      fn      <= '0;
      mcand   <= '0;
      acc     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      done_q  <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            fn      <= funct3;
            mcand   <= is_div ? mag_b : mag_a;
            acc     <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            cnt     <= CW'(XLEN);
            if (div_zero || div_ovf) begin
              result <= fast_val;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result <= final_val;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // start may still be high here: it is the same instruction moving on
          done_q <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign stall = ((state == IDLE) && start && !flush) || (state == BUSY);
  assign done  = done_q && !flush;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit with a queue-based scoreboard and arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall, done;
  logic [31:0] result;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [31:0] exp_res_q[$];
  int          exp_cyc_q[$];

  localparam logic [31:0] MIN_VAL = 32'h8000_0000;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb;                 return p[63:32]; end
      3'd2: begin p = sa * ub;                 return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_VAL && b == 32'hFFFF_FFFF) return MIN_VAL;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_VAL && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == MIN_VAL && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected response
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_res_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: done=1 with no outstanding op, result 0x%08h (cycle %0d)", result, cyc);
      end else begin
        chk("result", result, exp_res_q.pop_front());
        chk("done_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // Issue one op, hold start until done (as a stalled pipeline would), checking stall along the way
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    exp_res_q.push_back(exp);
    exp_cyc_q.push_back(cyc + latency(f, a, b));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      chk("stall_busy", stall, 1'b1);
    end
    if (seen) chk("stall_done", stall, 1'b0);
    else begin
      n_chk++;
      $display("FAIL done_timeout: no done within 40 cycles for funct3=%0d a=0x%08h b=0x%08h", f, a, b);
      void'(exp_res_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
  endtask

  task automatic issue_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    issue(f, a, b, ref_model(f, a, b));
  endtask

  initial begin
    int sel;
    logic [2:0]  f;
    logic [31:0] a, b;
    bit          any_done;

    rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_done", done, 1'b0);
    chk("reset_stall", stall, 1'b0);
    chk("reset_result", result, 32'h0);

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(3'd4, 32'd100, 32'd0, 32'hFFFF_FFFF);
    issue(3'd7, 32'd100, 32'd0, 32'd100);
    issue(3'd4, MIN_VAL, 32'hFFFF_FFFF, MIN_VAL);
    issue(3'd6, MIN_VAL, 32'hFFFF_FFFF, 32'h0);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    issue(3'd5, 32'd100, 32'd7, 32'd14);
    issue(3'd7, 32'd100, 32'd7, 32'd2);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Flush a DIV at T+10, release start at T+11, new op at T+12
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_done", done, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("flush_stall", stall, 1'b0);
    chk("flush_done_next", done, 1'b0);
    issue(3'd4, 32'd1000, 32'd3, 32'd333);

    // Reset in the middle of a multiply: no done pulse, result cleared
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd0; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    any_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) any_done = 1;
    end
    chk("rst_no_done", any_done, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_stall", stall, 1'b0);

    for (int n = 0; n < 48; n++) begin
      sel = $urandom_range(0, 9);
      f   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = MIN_VAL; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
      else if (sel == 3) b = 32'($urandom_range(0, 15)) - 32'd8;
      issue_ref(f, a, b);
    end

    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_res_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
